// File: rtl/mux4_scan_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mux4_scan_pkg
//  Purpose  : Shared types and constants for the mux_4x1 select scanner:
//             controller state encoding and channel index constants.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package mux4_scan_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } scan_state_e;

  localparam logic [1:0] CH_D0 = 2'd0;
  localparam logic [1:0] CH_D1 = 2'd1;
  localparam logic [1:0] CH_D2 = 2'd2;
  localparam logic [1:0] CH_D3 = 2'd3;

endpackage
`default_nettype wire

// File: rtl/mux4_dwell_cnt.sv
`default_nettype none
// ============================================================================
//  Module   : mux4_dwell_cnt
//  Purpose  : Per-channel dwell counter. Counts 0..DWELL-1 and wraps while
//             clr is low; held at zero while clr is high.
//  Ports    : clk       - system clock
//             rst_n     - asynchronous active-low reset
//             clr       - hold the count at zero
//             sample_en - count equals SETTLE (Y is stable, take the sample)
//             last      - count equals DWELL-1 (final cycle on this channel)
//  Revision : 1.0  initial release
// ============================================================================
module mux4_dwell_cnt #(
  parameter int DWELL  = 4,
  parameter int SETTLE = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic sample_en,
  output logic last
);

  localparam int CW = (DWELL > 2) ? $clog2(DWELL) : 1;

  logic [CW-1:0] dcnt_q;
  logic [CW-1:0] dcnt_d;

  assign sample_en = (dcnt_q == CW'(SETTLE));
  assign last      = (dcnt_q == CW'(DWELL - 1));

  // Explicit wrap on last so non-power-of-two dwell times work.
  always_comb begin
    dcnt_d = dcnt_q + CW'(1);
    if (clr || last) begin
      dcnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dcnt_q <= '0;
    end else begin
      dcnt_q <= dcnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mux4_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : mux4_scan_ctrl
//  Purpose  : Drives the {A,B} selects of a mux_4x1, samples its output Y
//             once per channel after a settle delay, and publishes the four
//             samples as a word with a one-cycle done strobe.
//  Ports    : clk        - system clock (rising edge)
//             rst_n      - asynchronous active-low reset
//             start      - request one scan (only honoured when idle)
//             continuous - start the next scan automatically after done
//             Y          - mux_4x1 output
//             A, B       - select MSB / LSB to mux_4x1
//             busy       - scan in progress (SCAN or DONE)
//             done       - one-cycle strobe when word_out updates
//             word_out   - last complete scan, bit i = channel Di
//  Revision : 1.0  initial release
// ============================================================================
module mux4_scan_ctrl
  import mux4_scan_pkg::*;
#(
  parameter int DWELL  = 4,
  parameter int SETTLE = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       continuous,
  input  logic       Y,
  output logic       A,
  output logic       B,
  output logic       busy,
  output logic       done,
  output logic [3:0] word_out
);

  if (DWELL < 2) begin : g_bad_dwell
    $error("mux4_scan_ctrl: DWELL must be >= 2");
  end
  if ((SETTLE < 0) || (SETTLE >= DWELL)) begin : g_bad_settle
    $error("mux4_scan_ctrl: SETTLE must be in 0..DWELL-1");
  end

  scan_state_e state_q, state_d;
  logic [1:0]  ch_q, ch_d;
  logic [3:0]  shadow_q, shadow_d;
  logic [3:0]  word_q, word_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        cnt_clr;
  logic        sample_en;
  logic        last;

  // The counter only runs in SCAN, so it is already at zero on entry.
  assign cnt_clr = (state_q != SCAN);

  mux4_dwell_cnt #(
    .DWELL  (DWELL),
    .SETTLE (SETTLE)
  ) u_dwell_cnt (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (cnt_clr),
    .sample_en (sample_en),
    .last      (last)
  );

  always_comb begin
    state_d  = state_q;
    ch_d     = ch_q;
    shadow_d = shadow_q;
    word_d   = word_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SCAN;
          ch_d    = CH_D0;
        end
      end
      SCAN: begin
        if (sample_en) begin
          shadow_d[ch_q] = Y;
        end
        if (last) begin
          if (ch_q == CH_D3) begin
            state_d = DONE;
            // shadow_d already includes a same-cycle D3 capture when
            // SETTLE == DWELL-1.
            word_d  = shadow_d;
          end else begin
            ch_d = ch_q + 2'd1;
          end
        end
      end
      DONE: begin
        // Select stays on D3 during DONE and returns to D0 afterwards.
        ch_d    = CH_D0;
        state_d = continuous ? SCAN : IDLE;
      end
      default: begin
        state_d = IDLE;
        ch_d    = CH_D0;
      end
    endcase
    // Status outputs are registered copies of the next state.
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      ch_q     <= CH_D0;
      shadow_q <= 4'b0000;
      word_q   <= 4'b0000;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ch_q     <= ch_d;
      shadow_q <= shadow_d;
      word_q   <= word_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign A        = ch_q[1];
  assign B        = ch_q[0];
  assign busy     = busy_q;
  assign done     = done_q;
  assign word_out = word_q;

endmodule
`default_nettype wire

// File: tb/tb_mux4_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mux4_scan_ctrl
//  Purpose  : Self-checking bench for mux4_scan_ctrl. Two instances share the
//             stimulus (SETTLE=1 and SETTLE=2, DWELL=4); each drives its own
//             copy of a 4:1 mux over the shared data inputs d[3:0].
//  Revision : 1.0  initial release
// ============================================================================
module tb_mux4_scan_ctrl;

  localparam int DW   = 4;
  localparam int SCAN = 4 * DW;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       continuous;
  logic [3:0] d;

  logic       a1, b1, busy1, done1, y1;
  logic [3:0] w1;
  logic       a2, b2, busy2, done2, y2;
  logic [3:0] w2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Behavioural 4:1 muxes in the loop: Y = D[{A,B}]
  assign y1 = d[{a1, b1}];
  assign y2 = d[{a2, b2}];

  mux4_scan_ctrl #(.DWELL(DW), .SETTLE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .continuous(continuous),
    .Y(y1), .A(a1), .B(b1), .busy(busy1), .done(done1), .word_out(w1)
  );

  mux4_scan_ctrl #(.DWELL(DW), .SETTLE(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start), .continuous(continuous),
    .Y(y2), .A(a2), .B(b2), .busy(busy2), .done(done2), .word_out(w2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_idle(input logic [3:0] e1, input logic [3:0] e2);
    check("idle_ab1",   32'({a1, b1}), 32'd0);
    check("idle_busy1", 32'(busy1),    32'd0);
    check("idle_done1", 32'(done1),    32'd0);
    check("idle_word1", 32'(w1),       32'(e1));
    check("idle_ab2",   32'({a2, b2}), 32'd0);
    check("idle_busy2", 32'(busy2),    32'd0);
    check("idle_done2", 32'(done2),    32'd0);
    check("idle_word2", 32'(w2),       32'(e2));
  endtask

  // Entered 1 time unit after the edge that starts the scan (k=0). Walks
  // 4*DW SCAN cycles plus the DONE cycle, checking every cycle, and returns
  // 1 time unit after the edge that leaves DONE.
  task automatic do_scan(input logic [3:0] p1, input logic [3:0] p2,
                         input bit rnd, input bit inj, input bit drop,
                         output logic [3:0] n1, output logic [3:0] n2);
    logic [3:0] e1;
    logic [3:0] e2;
    int ch;
    e1 = 4'b0000;
    e2 = 4'b0000;
    for (int k = 0; k <= SCAN; k++) begin
      ch = (k < SCAN) ? (k / DW) : 3;
      check("scan_ab1",   32'({a1, b1}), 32'(ch[1:0]));
      check("scan_ab2",   32'({a2, b2}), 32'(ch[1:0]));
      check("scan_busy1", 32'(busy1),    32'd1);
      check("scan_busy2", 32'(busy2),    32'd1);
      check("scan_done1", 32'(done1),    32'(k == SCAN));
      check("scan_done2", 32'(done2),    32'(k == SCAN));
      check("scan_word1", 32'(w1),       32'((k == SCAN) ? e1 : p1));
      check("scan_word2", 32'(w2),       32'((k == SCAN) ? e2 : p2));
      if (rnd) d = 4'($urandom);
      start = inj && (k == 5);
      if (drop && (k == 8)) continuous = 1'b0;
      // Value present on channel ch during the cycle it is sampled.
      if ((k < SCAN) && (k % DW == 1)) e1[k / DW] = d[k / DW];
      if ((k < SCAN) && (k % DW == 2)) e2[k / DW] = d[k / DW];
      @(posedge clk); #1;
    end
    start = 1'b0;
    n1 = e1;
    n2 = e2;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  initial begin
    logic [3:0] p1;
    logic [3:0] p2;
    bit running;
    bit cont;

    rst_n      = 1'b0;
    start      = 1'b0;
    continuous = 1'b0;
    d          = 4'b0000;
    p1         = 4'b0000;
    p2         = 4'b0000;

    repeat (2) @(posedge clk);
    #1;
    check_idle(4'b0000, 4'b0000);
    #2 rst_n = 1'b1;
    repeat (10) begin
      @(posedge clk); #1;
      check_idle(4'b0000, 4'b0000);
    end

    // Single scan, D0..D3 = 1,0,1,1
    d = 4'b1101;
    pulse_start();
    do_scan(p1, p2, 1'b0, 1'b0, 1'b0, p1, p2);
    check("dir_word1", 32'(w1), 32'h0000_000d);
    check_idle(p1, p2);

    // Continuous: first scan 0,1,1,0; D0 raised before the second scan
    // samples it; continuous dropped mid second scan, start pulsed at k=5.
    d          = 4'b0110;
    continuous = 1'b1;
    pulse_start();
    do_scan(p1, p2, 1'b0, 1'b0, 1'b0, p1, p2);
    check("cont_word1a", 32'(w1), 32'h0000_0006);
    d = 4'b0111;
    do_scan(p1, p2, 1'b0, 1'b1, 1'b1, p1, p2);
    check("cont_word1b", 32'(w1), 32'h0000_0007);
    check_idle(p1, p2);
    repeat (3) begin
      @(posedge clk); #1;
      check_idle(p1, p2);
    end

    // Asynchronous reset while on channel 2
    d = 4'b1010;
    pulse_start();
    repeat (9) @(posedge clk);
    #1;
    check("pre_rst_ab1", 32'({a1, b1}), 32'd2);
    #3 rst_n = 1'b0;
    #1;
    check_idle(4'b0000, 4'b0000);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    check_idle(4'b0000, 4'b0000);
    p1 = 4'b0000;
    p2 = 4'b0000;
    d  = 4'($urandom);
    pulse_start();
    do_scan(p1, p2, 1'b1, 1'b0, 1'b0, p1, p2);
    check_idle(p1, p2);

    // Randomised scans: data changes every cycle, random continuous chaining
    // and stray start pulses while busy.
    running = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cont = (i < 9) && ($urandom_range(0, 1) == 1);
      if (!running) begin
        repeat ($urandom_range(0, 3)) begin
          @(posedge clk); #1;
          check_idle(p1, p2);
        end
        pulse_start();
      end
      continuous = cont;
      do_scan(p1, p2, 1'b1, ($urandom_range(0, 1) == 1), 1'b0, p1, p2);
      running = cont;
      if (!cont) check_idle(p1, p2);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
